// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock datapath: keypad codes, the
// key-entry FSM encoding and the BCD digit limits of a 24-hour HH:MM time.
// Imported by key_entry_reg, time_validate, the time counter and the alarm
// register.
package alarm_pkg;

  // Keypad codes: 0-9 are digits, 10/11 commit, 12-15 carry no meaning.
  localparam logic [3:0] KEY_ALARM = 4'd10;
  localparam logic [3:0] KEY_TIME  = 4'd11;

  // Digit limits of a legal time 00:00..23:59.
  localparam logic [3:0] MS_HR_MAX     = 4'd2;  // tens of hours
  localparam logic [3:0] LS_HR_MAX_20S = 4'd3;  // units of hours when tens == 2
  localparam logic [3:0] MS_MIN_MAX    = 4'd5;  // tens of minutes
  localparam logic [3:0] DIGIT_MAX     = 4'd9;  // any BCD digit

  // A complete HH:MM entry holds four digits.
  localparam logic [2:0] DIGITS_FULL = 3'd4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } entry_state_e;

  function automatic logic is_digit_key(input logic [3:0] k);
    return k <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/time_validate.sv
// Combinational check that four BCD digits form a legal 24-hour time
// (00:00..23:59). Shared by the key-entry commit path and the alarm register.
// Ports:
//   ms_hr_i, ls_hr_i   : tens / units of hours
//   ms_min_i, ls_min_i : tens / units of minutes
//   valid_o            : 1 when the digits are a legal time
module time_validate
  import alarm_pkg::*;
(
  input  logic [3:0] ms_hr_i,
  input  logic [3:0] ls_hr_i,
  input  logic [3:0] ms_min_i,
  input  logic [3:0] ls_min_i,
  output logic       valid_o
);

  logic hr_ok;
  logic min_ok;

  always_comb begin
    // Hours 20-23 narrow the units digit; 00-19 allow any BCD units digit.
    if (ms_hr_i == MS_HR_MAX) begin
      hr_ok = (ls_hr_i <= LS_HR_MAX_20S);
    end else begin
      hr_ok = (ms_hr_i < MS_HR_MAX) && (ls_hr_i <= DIGIT_MAX);
    end
    min_ok  = (ms_min_i <= MS_MIN_MAX) && (ls_min_i <= DIGIT_MAX);
    valid_o = hr_ok && min_ok;
  end

endmodule

// File: rtl/key_entry_reg.sv
// Keypad entry stage of the alarm clock. Digit presses shift into a 4-digit
// BCD HH:MM buffer; TIME / ALARM commits a complete, legal entry as a
// one-cycle load pulse, otherwise as a one-cycle entry_error pulse. An open
// entry left untouched for TIMEOUT_S one_second pulses is dropped silently.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   one_second          : one-cycle pulse per second
//   key, key_valid      : key code and its strobe (see below)
//   key_buffer_*        : buffered HH:MM digits, loaded downstream
//   show_new_time       : high while an entry is open
//   load_new_c          : one-cycle pulse, buffer is a new current time
//   load_new_a          : one-cycle pulse, buffer is a new alarm time
//   entry_error         : one-cycle pulse, commit rejected
//
// Handshake: key_valid is a single-cycle strobe with no ready/backpressure;
// key is sampled only in a cycle where key_valid is high, and every strobe is
// consumed on that edge. Load/error pulses carry no handshake either: the
// buffer stays unchanged during the pulse so the receiver samples it then.
module key_entry_reg
  import alarm_pkg::*;
#(
  parameter int TIMEOUT_S = 10,
  parameter int TMR_W     = 4    // 2**TMR_W must exceed TIMEOUT_S
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic [3:0] key_buffer_ms_hr,
  output logic [3:0] key_buffer_ls_hr,
  output logic [3:0] key_buffer_ms_min,
  output logic [3:0] key_buffer_ls_min,
  output logic       show_new_time,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       entry_error
);

  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_S - 1);

  entry_state_e     state_q, state_d;
  logic [3:0]       ms_hr_q, ms_hr_d;
  logic [3:0]       ls_hr_q, ls_hr_d;
  logic [3:0]       ms_min_q, ms_min_d;
  logic [3:0]       ls_min_q, ls_min_d;
  logic [2:0]       count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             load_c_q, load_c_d;
  logic             load_a_q, load_a_d;
  logic             error_q, error_d;

  logic buf_valid;
  logic digit_press;
  logic commit_press;

  time_validate u_time_validate (
    .ms_hr_i (ms_hr_q),
    .ls_hr_i (ls_hr_q),
    .ms_min_i(ms_min_q),
    .ls_min_i(ls_min_q),
    .valid_o (buf_valid)
  );

  assign digit_press  = key_valid && is_digit_key(key);
  assign commit_press = key_valid && ((key == KEY_TIME) || (key == KEY_ALARM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ms_hr_q  <= 4'd0;
      ls_hr_q  <= 4'd0;
      ms_min_q <= 4'd0;
      ls_min_q <= 4'd0;
      count_q  <= 3'd0;
      timer_q  <= '0;
      load_c_q <= 1'b0;
      load_a_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ms_hr_q  <= ms_hr_d;
      ls_hr_q  <= ls_hr_d;
      ms_min_q <= ms_min_d;
      ls_min_q <= ls_min_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      load_c_q <= load_c_d;
      load_a_q <= load_a_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ms_hr_d  = ms_hr_q;
    ls_hr_d  = ls_hr_q;
    ms_min_d = ms_min_q;
    ls_min_d = ls_min_q;
    count_d  = count_q;
    timer_d  = timer_q;
    load_c_d = 1'b0;
    load_a_d = 1'b0;
    error_d  = 1'b0;

    // Priority: digit, then commit, then the timeout tick. A digit in the
    // same cycle as one_second clears the timer, so no timeout is taken.
    if (digit_press) begin
      if (state_q == ST_IDLE) begin
        // A fresh entry starts from 00:00 with the digit in the units place.
        ms_hr_d  = 4'd0;
        ls_hr_d  = 4'd0;
        ms_min_d = 4'd0;
        count_d  = 3'd1;
      end else begin
        ms_hr_d  = ls_hr_q;
        ls_hr_d  = ms_min_q;
        ms_min_d = ls_min_q;
        count_d  = (count_q == DIGITS_FULL) ? count_q : count_q + 3'd1;
      end
      ls_min_d = key;
      timer_d  = '0;
      state_d  = ST_ENTRY;
    end else if (commit_press && (state_q == ST_ENTRY)) begin
      if ((count_q == DIGITS_FULL) && buf_valid) begin
        load_c_d = (key == KEY_TIME);
        load_a_d = (key == KEY_ALARM);
      end else begin
        error_d = 1'b1;
      end
      // Buffer is left as is so it is stable while the pulse is high.
      count_d = 3'd0;
      timer_d = '0;
      state_d = ST_IDLE;
    end else if ((state_q == ST_ENTRY) && one_second) begin
      if (timer_q == TIMEOUT_LAST) begin
        count_d = 3'd0;
        timer_d = '0;
        state_d = ST_IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  assign key_buffer_ms_hr  = ms_hr_q;
  assign key_buffer_ls_hr  = ls_hr_q;
  assign key_buffer_ms_min = ms_min_q;
  assign key_buffer_ls_min = ls_min_q;
  assign show_new_time     = (state_q == ST_ENTRY);
  assign load_new_c        = load_c_q;
  assign load_new_a        = load_a_q;
  assign entry_error       = error_q;

endmodule

// File: tb/tb_key_entry_reg.sv
module tb_key_entry_reg;

  localparam int TIMEOUT_S = 10;
  localparam int TMR_W     = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       key_valid;
  logic [3:0] key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min;
  logic       show_new_time, load_new_c, load_new_a, entry_error;

  always #5 clk = ~clk;

  key_entry_reg #(.TIMEOUT_S(TIMEOUT_S), .TMR_W(TMR_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .one_second       (one_second),
    .key              (key),
    .key_valid        (key_valid),
    .key_buffer_ms_hr (key_buffer_ms_hr),
    .key_buffer_ls_hr (key_buffer_ls_hr),
    .key_buffer_ms_min(key_buffer_ms_min),
    .key_buffer_ls_min(key_buffer_ls_min),
    .show_new_time    (show_new_time),
    .load_new_c       (load_new_c),
    .load_new_a       (load_new_a),
    .entry_error      (entry_error)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  // {show, load_c, load_a, error, ms_hr, ls_hr, ms_min, ls_min}
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The entry is modelled as a list of typed digits and a "seconds since last
  // key" count; legality is judged on the numeric hour and minute.
  bit m_open;
  int m_d[4];
  int m_cnt;
  int m_secs;
  bit m_lc, m_la, m_err;

  function automatic logic [19:0] model_vec();
    return {m_open, m_lc, m_la, m_err,
            4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3])};
  endfunction

  task automatic model_reset();
    m_open = 0; m_cnt = 0; m_secs = 0;
    m_lc = 0; m_la = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_d[i] = 0;
  endtask

  task automatic model_step(input bit kv, input int k, input bit os);
    int hh, mm;
    m_lc = 0; m_la = 0; m_err = 0;
    if (kv && k <= 9) begin
      if (!m_open) for (int i = 0; i < 4; i++) m_d[i] = 0;
      for (int i = 0; i < 3; i++) m_d[i] = m_d[i+1];
      m_d[3] = k;
      m_cnt  = (m_cnt < 4) ? m_cnt + 1 : 4;
      m_secs = 0;
      m_open = 1;
    end else if (kv && (k == 10 || k == 11) && m_open) begin
      hh = m_d[0] * 10 + m_d[1];
      mm = m_d[2] * 10 + m_d[3];
      if (m_cnt == 4 && hh < 24 && mm < 60) begin
        if (k == 11) m_lc = 1; else m_la = 1;
      end else begin
        m_err = 1;
      end
      m_open = 0; m_cnt = 0; m_secs = 0;
    end else if (m_open && os) begin
      m_secs++;
      if (m_secs >= TIMEOUT_S) begin
        m_open = 0; m_cnt = 0; m_secs = 0;
      end
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic compare_outputs();
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 16'd1, 16'd0);
      return;
    end
    e = exp_q.pop_front();
    check("show_new_time", {15'd0, show_new_time}, {15'd0, e[19]});
    check("load_new_c",    {15'd0, load_new_c},    {15'd0, e[18]});
    check("load_new_a",    {15'd0, load_new_a},    {15'd0, e[17]});
    check("entry_error",   {15'd0, entry_error},   {15'd0, e[16]});
    check("buffer",
          {key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min},
          e[15:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit kv, input logic [3:0] k, input bit os);
    key_valid  = kv;
    key        = k;
    one_second = os;
    @(posedge clk);
    #1;
    model_step(kv, int'(k), os);
    compare_outputs();
    key_valid  = 1'b0;
    one_second = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    cycle(1'b1, k, 1'b0);
  endtask

  task automatic sec();
    cycle(1'b0, 4'd0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0);
  endtask

  // Reset is raised between edges; the driven key (possibly a commit that
  // would otherwise pulse) must have no effect.
  task automatic do_reset(input bit kv, input logic [3:0] k);
    key_valid = kv;
    key       = k;
    reset     = 1'b1;
    #2;
    model_reset();
    exp_q.push_back(model_vec());
    compare_outputs();
    @(posedge clk);
    #1;
    exp_q.push_back(model_vec());
    compare_outputs();
    reset     = 1'b0;
    key_valid = 1'b0;
  endtask

  function automatic logic [15:0] dut_buf();
    return {key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min};
  endfunction

  function automatic logic [15:0] dut_flags();
    return {12'd0, show_new_time, load_new_c, load_new_a, entry_error};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int hh, mm, n, dg[4];
    reset = 1'b1; key_valid = 1'b0; key = 4'd0; one_second = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    exp_q.push_back(model_vec());
    compare_outputs();
    check("reset_buf", dut_buf(), 16'h0000);
    check("reset_flags", dut_flags(), 16'h0000);
    reset = 1'b0;

    // TIME in IDLE right after reset: nothing happens.
    press(4'd11);
    check("time_in_idle_flags", dut_flags(), 16'h0000);
    idle(1);

    // Reset mid-entry, then a clean 12:34 load.
    press(4'd1); press(4'd2);
    check("mid_entry_buf", dut_buf(), 16'h0012);
    do_reset(1'b0, 4'd0);
    check("after_reset_buf", dut_buf(), 16'h0000);
    check("after_reset_flags", dut_flags(), 16'h0000);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'd11);
    check("load_1234_buf", dut_buf(), 16'h1234);
    check("load_1234_flags", dut_flags(), 16'b0100);
    idle(1);
    check("load_1234_one_cycle", dut_flags(), 16'h0000);

    // Hour bound.
    press(4'd2); press(4'd4); press(4'd0); press(4'd0); press(4'd10);
    check("alarm_2400_flags", dut_flags(), 16'b0001);
    press(4'd2); press(4'd3); press(4'd5); press(4'd9); press(4'd10);
    check("alarm_2359_flags", dut_flags(), 16'b0010);
    check("alarm_2359_buf", dut_buf(), 16'h2359);
    idle(1);

    // Short entry, then overflow by a 5th digit.
    press(4'd7); press(4'd5); press(4'd11);
    check("short_entry_flags", dut_flags(), 16'b0001);
    for (int i = 1; i <= 5; i++) press(4'(i));
    press(4'd11);
    check("overflow_buf", dut_buf(), 16'h2345);
    check("overflow_flags", dut_flags(), 16'b0100);
    idle(1);

    // Timeout after 10 idle seconds, then TIME is ignored.
    press(4'd9);
    for (int i = 0; i < TIMEOUT_S - 1; i++) sec();
    check("before_timeout_flags", dut_flags(), 16'b1000);
    sec();
    check("after_timeout_flags", dut_flags(), 16'h0000);
    check("after_timeout_buf", dut_buf(), 16'h0009);
    press(4'd11);
    check("time_after_timeout", dut_flags(), 16'h0000);

    // Digit coincident with the 10th second keeps the entry open; junk keys
    // do not restart the timeout.
    press(4'd5);
    for (int i = 0; i < TIMEOUT_S - 1; i++) sec();
    cycle(1'b1, 4'd3, 1'b1);
    check("coincident_flags", dut_flags(), 16'b1000);
    check("coincident_buf", dut_buf(), 16'h0053);
    for (int i = 0; i < 5; i++) sec();
    for (int k = 12; k <= 15; k++) press(4'(k));
    check("junk_buf", dut_buf(), 16'h0053);
    for (int i = 0; i < 4; i++) sec();
    check("junk_before_timeout", dut_flags(), 16'b1000);
    sec();
    check("junk_timeout", dut_flags(), 16'h0000);

    // Reset with a valid commit in flight: the pulse is suppressed.
    press(4'd0); press(4'd8); press(4'd1); press(4'd5);
    do_reset(1'b1, 4'd11);
    check("suppressed_flags", dut_flags(), 16'h0000);
    idle(1);

    // Randomised entries.
    for (int e = 0; e < 150; e++) begin
      if ($urandom_range(0, 2) != 0) begin
        hh = $urandom_range(0, 23); mm = $urandom_range(0, 59);
        dg[0] = hh / 10; dg[1] = hh % 10; dg[2] = mm / 10; dg[3] = mm % 10;
      end else begin
        for (int i = 0; i < 4; i++) dg[i] = $urandom_range(0, 9);
      end
      n = $urandom_range(0, 5);
      if (n == 5) cycle(1'b1, 4'($urandom_range(0, 9)), 1'($urandom_range(0, 3) == 0));
      for (int i = (n == 5 ? 0 : 4 - n); i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) cycle(1'b0, 4'd0, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 5) == 0) cycle(1'b1, 4'($urandom_range(12, 15)), 1'($urandom_range(0, 1)));
        cycle(1'b1, 4'(dg[i]), 1'($urandom_range(0, 3) == 0));
      end
      case ($urandom_range(0, 4))
        0: for (int i = 0; i < TIMEOUT_S + 1; i++) cycle(1'b0, 4'd0, 1'($urandom_range(0, 4) != 0));
        default: cycle(1'b1, 4'($urandom_range(10, 11)), 1'($urandom_range(0, 1)));
      endcase
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/key_entry_reg.md
Name: key_entry_reg

Overview:
- Upstream stage of the alarm-clock time counter.
- Collects keypad digit presses into a 4-digit BCD HH:MM buffer and validates it as a legal 24-hour time.
- On the TIME key it issues a one-cycle load_new_c; on the ALARM key it issues a one-cycle load_new_a.
- The counter loads its current-time digits from the buffer outputs when load_new_c pulses; the alarm register loads on load_new_a. An entry abandoned for TIMEOUT_S seconds is dropped.

Parameters:
- TIMEOUT_S, 10, number of one_second pulses without a key press before an open entry is abandoned.
- TMR_W, 4, width of the timeout counter; must satisfy 2^TMR_W > TIMEOUT_S.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- one_second  input  1  single-cycle pulse once per second, from the time generator
- key  input  4  key code: 0-9 digit, 10 ALARM, 11 TIME, 12-15 ignored
- key_valid  input  1  single-cycle strobe, one per debounced press; key is meaningful only when high
- key_buffer_ms_hr  output  4  tens-of-hours digit
- key_buffer_ls_hr  output  4  units-of-hours digit
- key_buffer_ms_min  output  4  tens-of-minutes digit
- key_buffer_ls_min  output  4  units-of-minutes digit
- show_new_time  output  1  high while an entry is open, so the display shows the buffer
- load_new_c  output  1  one-cycle pulse: buffer is a valid time for the counter
- load_new_a  output  1  one-cycle pulse: buffer is a valid alarm time
- entry_error  output  1  one-cycle pulse: commit rejected

Behaviour:
- Reset: all buffer digits are 0; state is IDLE; digit count and timer are 0; every output is 0.
- FSM states: IDLE, ENTRY. show_new_time = (state==ENTRY), decoded from the state register.
- Digit press (key_valid, key<=9), in either state:
  - Buffer shifts left on the next edge: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key.
  - Digit count increments and saturates at 4; a 5th or later digit keeps shifting with count held at 4.
  - Timer clears; state becomes ENTRY.
- Digit press from IDLE: the buffer is cleared to 0 first, so the first digit lands in ls_min and all other digits are 0.
- Commit (TIME or ALARM key) in ENTRY:
  - If count==4 and the buffer is valid: assert load_new_c (TIME) or load_new_a (ALARM) on the next cycle for exactly 1 cycle.
  - Otherwise: assert entry_error for 1 cycle; neither load pulse fires.
  - Either way: state returns to IDLE and count clears. The buffer is unchanged, so it is stable during the load pulse.
- Validity of the buffer:
  - ms_hr<=2;
  - ls_hr<=3 if ms_hr==2, else ls_hr<=9;
  - ms_min<=5;
  - ls_min<=9.
  - Range is 00:00..23:59.
- TIME or ALARM key in IDLE: ignored, no pulse. Key codes 12-15: ignored in all states and do not clear the timer.
- Timeout:
  - In ENTRY, each one_second pulse increments the timer.
  - When the timer reaches TIMEOUT_S, state returns to IDLE and count clears. No pulse fires; the buffer is retained.
- Simultaneous key_valid and one_second: the key takes priority, the timer clears, and no timeout occurs that cycle.
- Latency: buffer and state update 1 cycle after key_valid; load/error pulses are registered and appear 1 cycle after the commit key.
- Load, error and timeout are mutually exclusive; at most one pulse output is high in any cycle.
- Reset asserted mid-entry: immediate return to the reset values; any pending pulse is suppressed.
- Widths: all digits are 4-bit unsigned; the count is 3-bit; the timer is TMR_W bits and does not wrap before TIMEOUT_S.

Decomposition:
- Shared package alarm_pkg:
  - key code constants KEY_ALARM=4'd10 and KEY_TIME=4'd11;
  - FSM state encoding;
  - digit limits 2, 3, 5, 9.
  - The package is reused by the counter and the alarm register.
- One sub-module: time_validate, purely combinational, taking the four digits and returning valid. It is shared with the alarm register's load path.
- All remaining logic stays in key_entry_reg.

Test Plan:
- Reset mid-entry: reset after keys 1,2 (before any commit) -> buffer 0000, show_new_time=0, no pulse; after reset keys 1,2,3,4 then TIME -> buffer 1,2,3,4 and load_new_c high for exactly 1 cycle; the counter shows 12:34 on that edge.
- Hour-bound check: keys 2,4,0,0 then ALARM -> entry_error 1 cycle, load_new_a=0. Keys 2,3,5,9 then ALARM -> load_new_a 1 cycle with buffer 2,3,5,9.
- Short entry and overflow: keys 7,5 then TIME -> entry_error. Keys 1,2,3,4,5 then TIME -> buffer 2,3,4,5, valid, load_new_c pulse.
- Timeout: key 9 then 10 one_second pulses with no key -> show_new_time falls after the 10th pulse; a subsequent TIME -> no pulse (ignored in IDLE).
- Priority: key_valid (digit 3) coincident with the 10th one_second -> stays in ENTRY with timer cleared; keys 12-15 during entry -> buffer unchanged and the timeout is still taken at 10 s.
- TIME pressed in IDLE after reset -> no load_new_c, no entry_error, all outputs remain 0.
